// File: rtl/vga_text_pkg.sv
// Shared definitions for the 80x30 VGA text renderer.
//  - text geometry (COLS, ROWS, CELLS, CHAR_W, CHAR_H) and char RAM address width
//  - clear/write FSM state encoding
//  - terminal control codes
//  - cell_addr(): linear char RAM address of text cell (y, x)
//  - is_print(): byte is a printable ASCII character 0x20..0x7E
package vga_text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int ADDR_W = 12;

  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_BS = 8'h08;
  localparam logic [7:0] ASC_SP = 8'h20;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    CLRL = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] y, input logic [6:0] x);
    return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
  endfunction

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_font_rom.sv
// 128 x 16 x 8 synchronous font ROM, one clock read latency.
//  clk   in   pixel clock
//  addr  in   {char[6:0], font_row[3:0]}
//  q     out  8 pixels of that font row, bit 7 = leftmost pixel
// Codes 0x00..0x20 are blank. 'A' and 'H' carry their real glyphs; every
// other printable code shows a hollow box so it is still visible on screen.
module vga_font_rom
  import vga_text_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  q
);

  function automatic logic [7:0] glyph(input logic [6:0] code, input logic [3:0] line);
    logic [7:0] bits;
    bits = 8'h00;
    if (code == 7'h41) begin
      case (line)
        4'd2:                      bits = 8'h10;
        4'd3:                      bits = 8'h38;
        4'd4:                      bits = 8'h6C;
        4'd5, 4'd6:                bits = 8'hC6;
        4'd7:                      bits = 8'hFE;
        4'd8, 4'd9, 4'd10, 4'd11:  bits = 8'hC6;
        default:                   bits = 8'h00;
      endcase
    end else if (code == 7'h48) begin
      case (line)
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6: bits = 8'hC6;
        4'd7:                         bits = 8'hFE;
        4'd8, 4'd9, 4'd10, 4'd11:     bits = 8'hC6;
        default:                      bits = 8'h00;
      endcase
    end else if (code > 7'(ASC_SP)) begin
      case (line)
        4'd2, 4'd11:                                  bits = 8'h7E;
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: bits = 8'h42;
        default:                                      bits = 8'h00;
      endcase
    end
    return bits;
  endfunction

  always_ff @(posedge clk) q <= glyph(addr[10:4], addr[3:0]);

endmodule

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode pixel source for a 640x480 VGA timing stage.
//  clk, rst_n          25 MHz pixel clock, async active-low reset
//  row, colum          pixel coordinates from the timing stage
//  pixel_r/g/b         1-bit colour, valid 3 clocks after row/colum
//  wr_en, wr_data      terminal-style CPU byte port (ignored while busy)
//  busy                high during the power-on screen clear and line clears
//  cursor_x, cursor_y  current text cursor
// Optional feature: define VGA_TEXT_CURSOR_EN for a blinking underline
// cursor (font rows 14-15 of the cursor cell forced to foreground).
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter logic [2:0] FG_RGB     = 3'b111,
  parameter logic [2:0] BG_RGB     = 3'b001,
  parameter int         BLINK_LOG2 = 5
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] row,
  input  logic [11:0] colum,
  output logic        pixel_r,
  output logic        pixel_g,
  output logic        pixel_b,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam int STAGES = 3;
  localparam int RF_W   = $clog2(CHAR_H);
  localparam int CF_W   = $clog2(CHAR_W);

  // ---------------- CPU side: clear / write FSM ----------------
  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [7:0]          wdata;

  // Write port is driven combinationally so an accepted byte lands in the
  // RAM on the same edge that advances the cursor.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = ASC_SP;
    case (state)
      INIT: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      CLRL: begin
        we    = 1'b1;
        waddr = cell_addr(cursor_y, clr_cnt[6:0]);
      end
      IDLE: begin
        if (wr_en && is_print(wr_data)) begin
          we    = 1'b1;
          waddr = cell_addr(cursor_y, cursor_x);
          wdata = wr_data;
        end else if (wr_en && wr_data == ASC_BS && cursor_x != 7'd0) begin
          we    = 1'b1;
          waddr = cell_addr(cursor_y, cursor_x - 7'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      clr_cnt  <= '0;
      busy     <= 1'b1;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == ADDR_W'(CELLS-1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        CLRL: begin
          if (clr_cnt == ADDR_W'(COLS-1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (wr_en) begin
            // printable at the last column and LF both take the newline path
            if ((is_print(wr_data) && cursor_x == 7'(COLS-1)) || wr_data == ASC_LF) begin
              cursor_x <= '0;
              cursor_y <= (cursor_y == 5'(ROWS-1)) ? 5'd0 : cursor_y + 5'd1;
              state    <= CLRL;
              busy     <= 1'b1;
              clr_cnt  <= '0;
            end else if (is_print(wr_data)) begin
              cursor_x <= cursor_x + 7'd1;
            end else if (wr_data == ASC_CR) begin
              cursor_x <= '0;
            end else if (wr_data == ASC_BS && cursor_x != 7'd0) begin
              cursor_x <= cursor_x - 7'd1;
            end
          end
        end
        default: begin
          state <= INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- char RAM (simple dual port) ----------------
  logic [7:0]        char_mem [CELLS];
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        char_q;

  always_ff @(posedge clk) begin
    if (we) char_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) char_q <= char_mem[addr_q];

  // ---------------- display pipeline ----------------
  logic                  in_range;
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:1][RF_W-1:0] rf_pipe;
  logic [STAGES:1][CF_W-1:0] cf_pipe;
  logic [7:0]            font_q;
  logic                  cursor_force;
  logic                  unused_char_bit;

  assign in_range    = (row < 12'(ROWS*CHAR_H)) && (colum < 12'(COLS*CHAR_W));
  assign vld_pipe[0] = in_range;

  // Glyph index uses char bits 6:0 only.
  assign unused_char_bit = char_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Out-of-range coordinates read cell 0; the result is masked by vld_pipe.
  always_ff @(posedge clk) begin
    addr_q  <= in_range ? cell_addr(row[8:4], colum[9:3]) : '0;
    rf_pipe <= {rf_pipe[STAGES-1:1], row[RF_W-1:0]};
    cf_pipe <= {cf_pipe[STAGES-1:1], colum[CF_W-1:0]};
  end

  vga_font_rom u_font (
    .clk  (clk),
    .addr ({char_q[6:0], rf_pipe[2]}),
    .q    (font_q)
  );

`ifdef VGA_TEXT_CURSOR_EN
  logic [11:0]         prev_row;
  logic [BLINK_LOG2:0] frame_cnt;
  logic [STAGES:1]     cur_pipe;
  logic                cur_hit;

  assign cur_hit = in_range && row[8:4] == cursor_y && colum[9:3] == cursor_x;

  // A new frame starts when the timing stage wraps from the last line to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_row  <= '0;
      frame_cnt <= '0;
      cur_pipe  <= '0;
    end else begin
      prev_row <= row;
      cur_pipe <= {cur_pipe[STAGES-1:1], cur_hit};
      if (prev_row == 12'(ROWS*CHAR_H-1) && row == 12'd0)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign cursor_force = cur_pipe[STAGES] && frame_cnt[BLINK_LOG2] &&
                        (rf_pipe[STAGES] >= RF_W'(CHAR_H-2));
`else
  localparam int unused_blink = BLINK_LOG2;
  logic          unused_rf;
  assign unused_rf    = ^rf_pipe[STAGES];
  assign cursor_force = 1'b0;
`endif

  logic [2:0] rgb;
  always_comb begin
    rgb = BG_RGB;
    if (vld_pipe[STAGES] &&
        (cursor_force || font_q[CF_W'(CHAR_W-1) - cf_pipe[STAGES]]))
      rgb = FG_RGB;
  end

  assign {pixel_r, pixel_g, pixel_b} = rgb;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed self-checking bench for vga_text_renderer: power-on clear,
// glyph rendering, cursor movement, line clears, busy gating, range rule
// and (when VGA_TEXT_CURSOR_EN is defined) the blinking cursor overlay.
module tb_vga_text_renderer;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] row, colum;
  logic        pixel_r, pixel_g, pixel_b;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int n_chk = 0;
  int n_err = 0;

  // 'A' bitmap, one byte per font row, bit 7 leftmost
  logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  vga_text_renderer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .colum    (colum),
    .pixel_r  (pixel_r),
    .pixel_g  (pixel_g),
    .pixel_b  (pixel_b),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // drive a coordinate and return its pixel once the 3-stage pipe has produced it
  task automatic pix_at(input int r, input int c, output logic [2:0] rgb);
    row   = 12'(r);
    colum = 12'(c);
    repeat (3) @(negedge clk);
    rgb = {pixel_r, pixel_g, pixel_b};
  endtask

  // font row 5, pixel 0 is lit for both 'A' and 'H' and dark for a space
  task automatic probe(input int cy, input int cx, output logic [2:0] rgb);
    pix_at(cy*16 + 5, cx*8, rgb);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic put_char(input logic [7:0] c);
    int n;
    busy_len(n);
    if (busy) chk("wait_idle", 32'(busy), 32'd0);
    wr_en   = 1'b1;
    wr_data = c;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      row = 12'd479; colum = 12'd0;
      @(negedge clk);
      row = 12'd0;
      @(negedge clk);
    end
  endtask

  initial begin
    int         n, errs;
    logic [2:0] rgb;
    rst_n = 1'b0; row = '0; colum = '0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cx", 32'(cursor_x), 32'd0);
    chk("rst_cy", 32'(cursor_y), 32'd0);
    chk("rst_pix", 32'({pixel_r, pixel_g, pixel_b}), 32'(BG));

    // T1: power-on clear length, then a sparse frame scan is all background
    rst_n = 1'b1;
    busy_len(n);
    chk("init_busy_len", 32'(n), 32'd2400);
    errs = 0;
    for (int r = 0; r < 479; r += 7)
      for (int c = 0; c < 640; c += 9) begin
        pix_at(r, c, rgb);
        if (rgb !== BG) errs++;
      end
    chk("t1_frame_bg", 32'(errs), 32'd0);
    pix_at(478, 639, rgb);
    chk("t1_corner", 32'(rgb), 32'(BG));

    // T2: 'A' at (0,0) renders its bitmap
    put_char(8'h41);
    chk("t2_cx", 32'(cursor_x), 32'd1);
    chk("t2_cy", 32'(cursor_y), 32'd0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) begin
        pix_at(r, c, rgb);
        chk($sformatf("t2_A_r%0d_c%0d", r, c), 32'(rgb),
            32'(glyph_a[r][7-c] ? FG : BG));
      end

    // T3: a full line of 'H' wraps to row 1 and clears it
    put_char(8'h0D);
    chk("t3_cr_cx", 32'(cursor_x), 32'd0);
    for (int i = 0; i < 80; i++) put_char(8'h48);
    chk("t3_busy_rise", 32'(busy), 32'd1);
    busy_len(n);
    chk("t3_clr_len", 32'(n), 32'd80);
    chk("t3_cx", 32'(cursor_x), 32'd0);
    chk("t3_cy", 32'(cursor_y), 32'd1);
    errs = 0;
    for (int x = 0; x < 80; x++) begin
      probe(0, x, rgb);
      if (rgb !== FG) errs++;
    end
    chk("t3_row0_full", 32'(errs), 32'd0);
    errs = 0;
    for (int x = 0; x < 80; x++) begin
      probe(1, x, rgb);
      if (rgb !== BG) errs++;
    end
    chk("t3_row1_blank", 32'(errs), 32'd0);

    // T4: LF on the last row wraps to row 0 and clears it; writes while busy are dropped
    for (int i = 0; i < 28; i++) put_char(8'h0A);
    busy_len(n);
    chk("t4_cy29", 32'(cursor_y), 32'd29);
    put_char(8'h41);
    chk("t4_cx1", 32'(cursor_x), 32'd1);
    put_char(8'h0A);
    wr_en = 1'b1; wr_data = 8'h48;
    busy_len(n);
    wr_en = 1'b0;
    chk("t4_clr_len", 32'(n), 32'd80);
    chk("t4_cx", 32'(cursor_x), 32'd0);
    chk("t4_cy", 32'(cursor_y), 32'd0);
    errs = 0;
    for (int x = 0; x < 80; x++) begin
      probe(0, x, rgb);
      if (rgb !== BG) errs++;
    end
    chk("t4_row0_blank", 32'(errs), 32'd0);
    probe(29, 0, rgb);
    chk("t4_row29_kept", 32'(rgb), 32'(FG));

    // T5: backspace, ignored codes, range rule
    put_char(8'h08);
    chk("t5_bs0_cx", 32'(cursor_x), 32'd0);
    chk("t5_bs0_cy", 32'(cursor_y), 32'd0);
    chk("t5_bs0_busy", 32'(busy), 32'd0);
    put_char(8'h07);
    chk("t5_bel_cx", 32'(cursor_x), 32'd0);
    chk("t5_bel_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) put_char(8'h48);
    chk("t5_cx5", 32'(cursor_x), 32'd5);
    put_char(8'h08);
    chk("t5_bs_cx4", 32'(cursor_x), 32'd4);
    probe(0, 4, rgb);
    chk("t5_cell4_blank", 32'(rgb), 32'(BG));
    probe(0, 3, rgb);
    chk("t5_cell3_kept", 32'(rgb), 32'(FG));
    pix_at(5, 0, rgb);
    chk("t5_in_range", 32'(rgb), 32'(FG));
    pix_at(5, 700, rgb);
    chk("t5_col700", 32'(rgb), 32'(BG));
    pix_at(600, 0, rgb);
    chk("t5_row600", 32'(rgb), 32'(BG));
    pix_at(480, 0, rgb);
    chk("t5_row480", 32'(rgb), 32'(BG));

    // T6: cursor overlay on (0,4)
    pix_at(14, 32, rgb);
    chk("t6_pre", 32'(rgb), 32'(BG));
    frames(32);
`ifdef VGA_TEXT_CURSOR_EN
    pix_at(14, 32, rgb);
    chk("t6_on_r14", 32'(rgb), 32'(FG));
    pix_at(15, 39, rgb);
    chk("t6_on_r15", 32'(rgb), 32'(FG));
    pix_at(13, 32, rgb);
    chk("t6_on_r13", 32'(rgb), 32'(BG));
    pix_at(14, 40, rgb);
    chk("t6_on_next_cell", 32'(rgb), 32'(BG));
    frames(32);
    pix_at(14, 32, rgb);
    chk("t6_off_r14", 32'(rgb), 32'(BG));
`else
    pix_at(14, 32, rgb);
    chk("t6_never_r14", 32'(rgb), 32'(BG));
    pix_at(15, 39, rgb);
    chk("t6_never_r15", 32'(rgb), 32'(BG));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
